axis_rx_check_module: RTL and testbench
=======================================

# axis_rx_check_module

Receive-side traffic checker for the 10G Ethernet loopback design. It is the counterpart of the AXIS TX test generator and sits on the MAC's receive AXI-Stream output (m_axis_r*, o_crc_error/o_crc_valid) in the XGMII clock domain. It checks every received frame's payload pattern, length and CRC status, and keeps saturating statistics counters for ILA/VIO readout. The MAC RX stream has no back-pressure, so the checker accepts every beat.

## Interface
Parameters:
- P_PATTERN_SEED, 64'h0, expected value of payload beat 0; beat k expects seed + k (64-bit wrap).
- P_MIN_LEN, 16'd46, minimum legal frame byte count.
- P_MAX_LEN, 16'd1500, maximum legal frame byte count.
- P_CRC_TIMEOUT, 8'd16, cycles after the last beat to wait for crc_valid.

Ports:
- i_clk  in  1  XGMII clock; one clock; all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- s_axis_rdata  in  64  receive data; byte 0 = bits [7:0].
- s_axis_ruser  in  80  sideband; [15:0] = frame byte count, valid on first beat.
- s_axis_rkeep  in  8  byte enables.
- s_axis_rlast  in  1  last beat of frame.
- s_axis_rvalid  in  1  beat valid (no ready).
- i_crc_valid  in  1  one-cycle CRC result strobe.
- i_crc_error  in  1  CRC failed; qualified by i_crc_valid.
- o_frame_done  out  1  one-cycle pulse per completed frame check.
- o_frame_ok  out  1  result of last frame; valid with o_frame_done, held after.
- o_err_sticky  out  1  set on any error, cleared only by reset.
- o_frame_cnt  out  32  frames checked.
- o_good_cnt  out  32  frames with no error.
- o_data_err_cnt  out  32  frames with ≥1 payload mismatch.
- o_len_err_cnt  out  32  frames with length/keep error.
- o_crc_err_cnt  out  32  frames with CRC error or CRC timeout.

## Operation
- States: IDLE, PAYLOAD, WAIT_CRC.
- IDLE: rvalid beat = first beat; latch ruser[15:0] as expected length, clear per-frame flags, beat index = 0. If rlast on same beat -> WAIT_CRC, else -> PAYLOAD.
- Every beat (IDLE first beat and PAYLOAD): compare enabled bytes of rdata with P_PATTERN_SEED + beat index; any mismatch sets data flag. Beat index 16-bit, increments per beat.
- Keep rules: non-last beat must be 8'hFF; last beat must be one of 8'h01,03,07,0F,1F,3F,7F,FF. Violation sets len flag. Byte count accumulates popcount(rkeep) per beat (16-bit, saturating at 16'hFFFF).
- At frame end: len flag also set if byte count != latched length, or outside [P_MIN_LEN, P_MAX_LEN].
- WAIT_CRC: timer counts from 0; i_crc_valid -> crc flag = i_crc_error, complete. Timer reaching P_CRC_TIMEOUT -> crc flag set, complete. Return to IDLE.
- i_crc_valid in the same cycle as the rlast beat is accepted as that frame's result (skip WAIT_CRC, complete directly).
- i_crc_valid in IDLE or PAYLOAD is ignored.
- rvalid first beat while in WAIT_CRC: current frame completes with crc flag set (timeout), new frame starts on that beat (-> PAYLOAD/WAIT_CRC per rlast).
- Completion: o_frame_cnt +1; exactly one of good/error classification: good_cnt +1 if no flag; each set flag increments its own counter (a frame may bump several). All counters saturate at 32'hFFFF_FFFF.
- Reset mid-frame: state -> IDLE, partial frame discarded, not counted.

## Timing
- Reset values: all counters 0, o_frame_done 0, o_frame_ok 0, o_err_sticky 0, state IDLE.
- Completion event at edge N (crc_valid sampled or timeout) -> o_frame_done high for cycle N+1, counters/o_frame_ok/o_err_sticky updated at same edge.
- Back-to-back frames with zero idle cycles supported: beat of next frame may arrive the cycle after rlast.
- Timeout: with rlast at cycle T and no crc_valid, completion at cycle T+P_CRC_TIMEOUT.

## Test plan
- 64-byte frame, 8 beats, data seed+0..seed+7, rkeep last 8'hFF, ruser=64, crc_valid/error=1/0 two cycles after rlast -> one o_frame_done, o_frame_ok=1, frame_cnt=1, good_cnt=1.
- 61-byte frame, last rkeep 8'h1F, beat 3 data bit 0 flipped -> data_err_cnt=1, good_cnt=0, o_err_sticky=1; second flip on enabled-out byte of last beat -> not counted.
- Length mismatch: ruser=72, 64 bytes sent; then last rkeep 8'h0B -> len_err_cnt=2; 40-byte frame with ruser=40 -> len_err_cnt=3.
- CRC: crc_error=1 -> crc_err_cnt=1; no crc_valid for 16 cycles -> crc_err_cnt=2 at T+16; crc_valid with rlast same cycle -> accepted, good_cnt +1.
- 100 back-to-back 64-byte frames, crc_valid coincident with each rlast -> frame_cnt=good_cnt=100; new frame first beat during WAIT_CRC -> previous counted as CRC error, new frame checked normally.
- Assert i_rst asynchronously mid-frame (beat 4 of 8) -> all outputs 0 immediately; next full frame after release counted, frame_cnt=1.

Source files
------------

// File: rtl/axis_rx_check_module_if.sv
// MAC receive AXI-Stream beat bus plus CRC result strobe, no ready (the sink must accept every beat).
interface axis_rx_check_module_if;
  logic [63:0] rdata;
  logic [79:0] ruser;
  logic [7:0]  rkeep;
  logic        rlast;
  logic        rvalid;
  logic        crc_valid;
  logic        crc_error;

  modport master (output rdata, ruser, rkeep, rlast, rvalid, crc_valid, crc_error);
  modport slave  (input  rdata, ruser, rkeep, rlast, rvalid, crc_valid, crc_error);
endinterface

// File: rtl/axis_rx_check_module.sv
// RX frame checker: payload pattern, length/keep and CRC status with saturating stats.
// Result one cycle after the completing edge; never back-pressures (no ready on the MAC RX stream).
module axis_rx_check_module #(
  parameter logic [63:0] P_PATTERN_SEED = 64'h0,
  parameter logic [15:0] P_MIN_LEN      = 16'd46,
  parameter logic [15:0] P_MAX_LEN      = 16'd1500,
  parameter logic [7:0]  P_CRC_TIMEOUT  = 8'd16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  axis_rx_check_module_if.slave         s_axis,
  output logic                          o_frame_done,
  output logic                          o_frame_ok,
  output logic                          o_err_sticky,
  output logic [31:0]                   o_frame_cnt,
  output logic [31:0]                   o_good_cnt,
  output logic [31:0]                   o_data_err_cnt,
  output logic [31:0]                   o_len_err_cnt,
  output logic [31:0]                   o_crc_err_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_WAIT_CRC} state_e;

  state_e      state_q, state_d;
  logic [15:0] exp_len_q, exp_len_d;
  logic [15:0] beat_idx_q, beat_idx_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        data_flag_q, data_flag_d;
  logic        len_flag_q, len_flag_d;
  logic [7:0]  timer_q, timer_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic        sticky_q, sticky_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] good_cnt_q, good_cnt_d;
  logic [31:0] data_cnt_q, data_cnt_d;
  logic [31:0] len_cnt_q, len_cnt_d;
  logic [31:0] crc_cnt_q, crc_cnt_d;

  logic        first_beat;
  logic [15:0] idx;
  logic [63:0] exp_word;
  logic [7:0]  byte_mis;
  logic [3:0]  keep_pop;
  logic        keep_bad;
  logic [16:0] cnt_sum;
  logic [15:0] cnt_sat;
  logic [15:0] len_ref;
  logic        beat_data_flag;
  logic        beat_len_flag;
  logic        cmp_vld, cmp_data, cmp_len, cmp_crc, cmp_ok;

  logic unused_ruser;
  assign unused_ruser = &{1'b0, s_axis.ruser[79:16]};

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Evaluation of the beat on the bus, as if it were accepted this cycle.
  always_comb begin
    first_beat = (state_q != ST_PAYLOAD);
    idx        = first_beat ? 16'd0 : beat_idx_q;
    exp_word   = P_PATTERN_SEED + {48'd0, idx};
    keep_pop   = 4'd0;
    byte_mis   = 8'd0;
    for (int b = 0; b < 8; b++) begin
      keep_pop    = keep_pop + {3'd0, s_axis.rkeep[b]};
      byte_mis[b] = s_axis.rkeep[b] && (s_axis.rdata[8*b +: 8] != exp_word[8*b +: 8]);
    end
    if (s_axis.rlast) begin
      keep_bad = !(s_axis.rkeep inside {8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF});
    end else begin
      keep_bad = (s_axis.rkeep != 8'hFF);
    end
    cnt_sum        = {1'b0, (first_beat ? 16'd0 : byte_cnt_q)} + {13'd0, keep_pop};
    cnt_sat        = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    len_ref        = first_beat ? s_axis.ruser[15:0] : exp_len_q;
    beat_data_flag = (!first_beat && data_flag_q) || (|byte_mis);
    beat_len_flag  = (!first_beat && len_flag_q) || keep_bad ||
                     (s_axis.rlast && ((cnt_sat != len_ref) || (cnt_sat < P_MIN_LEN) ||
                                       (cnt_sat > P_MAX_LEN)));
  end

  always_comb begin
    state_d     = state_q;
    exp_len_d   = exp_len_q;
    beat_idx_d  = beat_idx_q;
    byte_cnt_d  = byte_cnt_q;
    data_flag_d = data_flag_q;
    len_flag_d  = len_flag_q;
    timer_d     = timer_q;
    done_d      = 1'b0;
    ok_d        = ok_q;
    sticky_d    = sticky_q;
    frame_cnt_d = frame_cnt_q;
    good_cnt_d  = good_cnt_q;
    data_cnt_d  = data_cnt_q;
    len_cnt_d   = len_cnt_q;
    crc_cnt_d   = crc_cnt_q;
    cmp_vld     = 1'b0;
    cmp_data    = 1'b0;
    cmp_len     = 1'b0;
    cmp_crc     = 1'b0;
    cmp_ok      = 1'b0;

    // A strobe, a timeout or the next frame's first beat all close the waiting frame.
    if (state_q == ST_WAIT_CRC) begin
      if (s_axis.crc_valid || s_axis.rvalid || ((timer_q + 8'd1) >= P_CRC_TIMEOUT)) begin
        cmp_vld  = 1'b1;
        cmp_data = data_flag_q;
        cmp_len  = len_flag_q;
        cmp_crc  = s_axis.crc_valid ? s_axis.crc_error : 1'b1;
        state_d  = ST_IDLE;
      end else begin
        timer_d = timer_q + 8'd1;
      end
    end

    if (s_axis.rvalid) begin
      exp_len_d   = len_ref;
      byte_cnt_d  = cnt_sat;
      data_flag_d = beat_data_flag;
      len_flag_d  = beat_len_flag;
      beat_idx_d  = idx + 16'd1;
      timer_d     = 8'd0;
      if (!s_axis.rlast) begin
        state_d = ST_PAYLOAD;
      end else if (s_axis.crc_valid && (state_q != ST_WAIT_CRC)) begin
        cmp_vld  = 1'b1;
        cmp_data = beat_data_flag;
        cmp_len  = beat_len_flag;
        cmp_crc  = s_axis.crc_error;
        state_d  = ST_IDLE;
      end else begin
        state_d = ST_WAIT_CRC;
      end
    end

    if (cmp_vld) begin
      cmp_ok      = !(cmp_data || cmp_len || cmp_crc);
      done_d      = 1'b1;
      ok_d        = cmp_ok;
      sticky_d    = sticky_q || !cmp_ok;
      frame_cnt_d = sat_inc(frame_cnt_q);
      if (cmp_ok)   good_cnt_d = sat_inc(good_cnt_q);
      if (cmp_data) data_cnt_d = sat_inc(data_cnt_q);
      if (cmp_len)  len_cnt_d  = sat_inc(len_cnt_q);
      if (cmp_crc)  crc_cnt_d  = sat_inc(crc_cnt_q);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      exp_len_q   <= 16'd0;
      beat_idx_q  <= 16'd0;
      byte_cnt_q  <= 16'd0;
      data_flag_q <= 1'b0;
      len_flag_q  <= 1'b0;
      timer_q     <= 8'd0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      sticky_q    <= 1'b0;
      frame_cnt_q <= 32'd0;
      good_cnt_q  <= 32'd0;
      data_cnt_q  <= 32'd0;
      len_cnt_q   <= 32'd0;
      crc_cnt_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      exp_len_q   <= exp_len_d;
      beat_idx_q  <= beat_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      data_flag_q <= data_flag_d;
      len_flag_q  <= len_flag_d;
      timer_q     <= timer_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      sticky_q    <= sticky_d;
      frame_cnt_q <= frame_cnt_d;
      good_cnt_q  <= good_cnt_d;
      data_cnt_q  <= data_cnt_d;
      len_cnt_q   <= len_cnt_d;
      crc_cnt_q   <= crc_cnt_d;
    end
  end

  assign o_frame_done   = done_q;
  assign o_frame_ok     = ok_q;
  assign o_err_sticky   = sticky_q;
  assign o_frame_cnt    = frame_cnt_q;
  assign o_good_cnt     = good_cnt_q;
  assign o_data_err_cnt = data_cnt_q;
  assign o_len_err_cnt  = len_cnt_q;
  assign o_crc_err_cnt  = crc_cnt_q;

endmodule

// File: tb/tb_axis_rx_check_module.sv
// Randomized frame stimulus checked against a per-frame reference model of the RX checker.
module tb_axis_rx_check_module;
  localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDE0;
  localparam int          TMO  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_frame_done, o_frame_ok, o_err_sticky;
  logic [31:0] o_frame_cnt, o_good_cnt, o_data_err_cnt, o_len_err_cnt, o_crc_err_cnt;

  axis_rx_check_module_if bus ();

  axis_rx_check_module #(
    .P_PATTERN_SEED (SEED),
    .P_MIN_LEN      (16'd46),
    .P_MAX_LEN      (16'd1500),
    .P_CRC_TIMEOUT  (8'(TMO))
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .s_axis         (bus),
    .o_frame_done   (o_frame_done),
    .o_frame_ok     (o_frame_ok),
    .o_err_sticky   (o_err_sticky),
    .o_frame_cnt    (o_frame_cnt),
    .o_good_cnt     (o_good_cnt),
    .o_data_err_cnt (o_data_err_cnt),
    .o_len_err_cnt  (o_len_err_cnt),
    .o_crc_err_cnt  (o_crc_err_cnt)
  );

  initial forever #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_frame, m_good, m_data, m_len, m_crc;
  bit          m_sticky;
  bit          exp_ok_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Every result pulse must match the oldest outstanding frame's predicted outcome.
  always @(negedge clk) begin
    if (o_frame_done === 1'b1) begin
      if (exp_ok_q.size() == 0) chk("spurious_done", 32'(o_frame_done), 32'd0);
      else chk("frame_ok", 32'(o_frame_ok), 32'(exp_ok_q.pop_front()));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rvalid    = 1'b0;
      bus.rlast     = 1'b0;
      bus.crc_valid = 1'b0;
      bus.crc_error = 1'($urandom);
      bus.rdata     = {$urandom, $urandom};
      bus.rkeep     = 8'($urandom);
    end
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_frame_cnt"}, o_frame_cnt, m_frame);
    chk({tag, "_good_cnt"},  o_good_cnt,  m_good);
    chk({tag, "_data_cnt"},  o_data_err_cnt, m_data);
    chk({tag, "_len_cnt"},   o_len_err_cnt,  m_len);
    chk({tag, "_crc_cnt"},   o_crc_err_cnt,  m_crc);
    chk({tag, "_sticky"},    32'(o_err_sticky), 32'(m_sticky));
  endtask

  // crc_mode: 0 strobe ok, 1 strobe error, 2 no strobe (timeout), 3 strobe with rlast,
  // 4 no strobe and the caller starts the next frame on the following cycle.
  task automatic send_frame(input int nbytes, input int ruser_len, input int flip_beat,
                            input int flip_byte, input logic [7:0] keep_ovr,
                            input int crc_mode, input int crc_delay);
    int          nbeats, sent, j;
    logic [7:0]  lkeep;
    logic [63:0] word;
    logic [79:0] usr;
    bit          keep_ok, data_e, len_e, crc_e, ok;
    nbeats = (nbytes + 7) / 8;
    lkeep  = (nbytes % 8 == 0) ? 8'hFF : 8'((1 << (nbytes % 8)) - 1);
    if (keep_ovr != 8'h00) lkeep = keep_ovr;
    sent    = 8 * (nbeats - 1) + $countones(lkeep);
    keep_ok = ((int'(lkeep) & (int'(lkeep) + 1)) == 0);
    data_e  = (flip_beat >= 0) && (flip_beat < nbeats) &&
              ((flip_beat < nbeats - 1) || lkeep[flip_byte]);
    len_e   = !keep_ok || (sent != ruser_len) || (sent < 46) || (sent > 1500);
    crc_e   = (crc_mode == 1) || (crc_mode == 2) || (crc_mode == 4);
    ok      = !(data_e || len_e || crc_e);
    exp_ok_q.push_back(ok);
    m_frame = m_frame + 1;
    if (ok)    m_good = m_good + 1;
    if (data_e) m_data = m_data + 1;
    if (len_e) m_len  = m_len + 1;
    if (crc_e) m_crc  = m_crc + 1;
    if (!ok)   m_sticky = 1'b1;

    for (int k = 0; k < nbeats; k++) begin
      @(negedge clk);
      word = SEED + 64'(k);
      if (k == nbeats - 1)
        for (int b = 0; b < 8; b++)
          if (!lkeep[b]) word[8*b +: 8] = 8'($urandom);
      if (k == flip_beat) word[8*flip_byte] = ~word[8*flip_byte];
      usr = 80'({$urandom, $urandom, $urandom});
      if (k == 0) usr[15:0] = 16'(ruser_len);
      bus.rdata     = word;
      bus.ruser     = usr;
      bus.rkeep     = (k == nbeats - 1) ? lkeep : 8'hFF;
      bus.rlast     = (k == nbeats - 1);
      bus.rvalid    = 1'b1;
      bus.crc_valid = (crc_mode == 3) && (k == nbeats - 1);
      bus.crc_error = bus.crc_valid ? 1'b0 : 1'($urandom);
    end

    if (crc_mode == 0 || crc_mode == 1) begin
      idle(crc_delay);
      @(negedge clk);
      bus.rvalid    = 1'b0;
      bus.rlast     = 1'b0;
      bus.crc_valid = 1'b1;
      bus.crc_error = (crc_mode == 1);
    end else if (crc_mode == 2) begin
      for (j = 0; j < 40; j++) begin
        idle(1);
        if (o_frame_done === 1'b1) break;
      end
      chk("crc_timeout_latency", 32'(j), 32'(TMO));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb, ru, fb, md;
    logic [7:0] ko;
    m_frame = 0; m_good = 0; m_data = 0; m_len = 0; m_crc = 0; m_sticky = 1'b0;
    bus.rdata = '0; bus.ruser = '0; bus.rkeep = '0; bus.rlast = 1'b0;
    bus.rvalid = 1'b0; bus.crc_valid = 1'b0; bus.crc_error = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(o_frame_done), 32'd0);
    chk("rst_ok", 32'(o_frame_ok), 32'd0);
    check_counters("rst");
    rst = 1'b0;
    idle(2);

    send_frame(64, 64, -1, 0, 8'h00, 0, 2);
    idle(4);
    check_counters("good64");
    chk("good64_good_const", o_good_cnt, 32'd1);

    send_frame(61, 61, 3, 0, 8'h00, 0, 1);
    send_frame(61, 61, 7, 6, 8'h00, 0, 1);
    idle(4);
    check_counters("data");
    chk("data_err_const", o_data_err_cnt, 32'd1);

    send_frame(64, 72, -1, 0, 8'h00, 0, 0);
    send_frame(64, 59, -1, 0, 8'h0B, 0, 0);
    send_frame(40, 40, -1, 0, 8'h00, 0, 3);
    idle(4);
    check_counters("len");
    chk("len_err_const", o_len_err_cnt, 32'd3);

    send_frame(64, 64, -1, 0, 8'h00, 1, 2);
    send_frame(64, 64, -1, 0, 8'h00, 2, 0);
    send_frame(64, 64, -1, 0, 8'h00, 3, 0);
    idle(4);
    check_counters("crc");
    chk("crc_err_const", o_crc_err_cnt, 32'd2);

    repeat (100) send_frame(64, 64, -1, 0, 8'h00, 3, 0);
    idle(4);
    check_counters("b2b");
    send_frame(64, 64, -1, 0, 8'h00, 4, 0);
    send_frame(64, 64, -1, 0, 8'h00, 0, 1);
    idle(4);
    check_counters("overlap");

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.rdata = SEED + 64'(k); bus.ruser = 80'd64; bus.rkeep = 8'hFF;
      bus.rlast = 1'b0; bus.rvalid = 1'b1; bus.crc_valid = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_done", 32'(o_frame_done), 32'd0);
    chk("arst_ok", 32'(o_frame_ok), 32'd0);
    m_frame = 0; m_good = 0; m_data = 0; m_len = 0; m_crc = 0; m_sticky = 1'b0;
    check_counters("arst");
    exp_ok_q.delete();
    idle(1);
    rst = 1'b0;
    idle(2);
    send_frame(64, 64, -1, 0, 8'h00, 0, 1);
    idle(4);
    check_counters("post_rst");
    chk("post_rst_frame_const", o_frame_cnt, 32'd1);

    for (int i = 0; i < 40; i++) begin
      nb = $urandom_range(30, 200);
      ru = ($urandom_range(0, 5) == 0) ? nb + $urandom_range(1, 3) : nb;
      fb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (nb + 7) / 8 - 1) : -1;
      ko = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      md = $urandom_range(0, 4);
      if (i == 39 && md == 4) md = 0;
      send_frame(nb, ru, fb, $urandom_range(0, 7), ko, md, $urandom_range(0, 5));
    end
    idle(6);
    check_counters("random");
    chk("pending_frames", 32'(exp_ok_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
